// File: rtl/sprite_motion_seq_if.sv
// Engine register-write bus between the motion sequencer and the sprite engine.
// Valid/ready handshake; a beat transfers when wr_valid and wr_ready are both high.
interface sprite_motion_seq_if;
   logic        wr_valid;
   logic        wr_ready;
   logic [5:0]  wr_addr;
   logic [15:0] wr_data;
   logic [1:0]  wr_size;

   modport master (
      output wr_valid, wr_addr, wr_data, wr_size,
      input  wr_ready
   );

   modport slave (
      input  wr_valid, wr_addr, wr_data, wr_size,
      output wr_ready
   );
endinterface

// File: rtl/sprite_motion_seq.sv
// Frame-rate motion sequencer for the 2-sprite engine: steps both sprites with
// edge bounce on each VSYNC rise, then pauses, rewrites coords and resumes.
module sprite_motion_seq #(
   parameter int X_MAX = 248,
   parameter int Y_MAX = 184
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       vsync,
   input  logic                       cfg_we,
   input  logic [2:0]                 cfg_addr,
   input  logic [7:0]                 cfg_wdata,
   sprite_motion_seq_if.master        bus,
   output logic [15:0]                pos0,
   output logic [15:0]                pos1,
   output logic                       busy,
   output logic                       frame_miss
);

   localparam logic [7:0] XM = 8'(X_MAX);
   localparam logic [7:0] YM = 8'(Y_MAX);

   typedef enum logic [2:0] {
      IDLE, CALC, WR_STOP, WR_P0, WR_P1, WR_GO
   } state_t;

   state_t      state;
   logic        vsync_q;
   logic        run;
   logic        irq_en;
   logic [7:0]  x0, y0, x1, y1;
   logic [3:0]  vx0, vy0, vx1, vy1;
   logic        vs_rise;
   logic        xfer;

   assign vs_rise     = vsync & ~vsync_q;
   assign xfer        = bus.wr_valid & bus.wr_ready;
   assign bus.wr_size = 2'b01;
   assign pos0        = {y0, x0};
   assign pos1        = {y1, x1};

   // Returns {new_velocity, new_position}; a bounce pins to the wall and flips v.
   function automatic logic [11:0] step(input logic [7:0] p,
                                        input logic [3:0] v,
                                        input logic [7:0] lim);
      logic [9:0] n;
      n = {2'b00, p} + {{6{v[3]}}, v};
      if (n[9])
         step = {~v + 4'd1, 8'd0};
      else if (n > {2'b00, lim})
         step = {~v + 4'd1, lim};
      else
         step = {v, n[7:0]};
   endfunction

   function automatic logic [3:0] fix_vel(input logic [3:0] v);
      fix_vel = (v == 4'b1000) ? 4'b1001 : v;
   endfunction

   function automatic logic [7:0] clamp(input logic [7:0] d,
                                        input logic [7:0] lim);
      clamp = (d > lim) ? lim : d;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         vsync_q      <= 1'b0;
         run          <= 1'b0;
         irq_en       <= 1'b0;
         x0           <= 8'd0;
         y0           <= 8'd0;
         x1           <= 8'd0;
         y1           <= 8'd0;
         vx0          <= 4'd0;
         vy0          <= 4'd0;
         vx1          <= 4'd0;
         vy1          <= 4'd0;
         bus.wr_valid <= 1'b0;
         bus.wr_addr  <= 6'd0;
         bus.wr_data  <= 16'd0;
         busy         <= 1'b0;
         frame_miss   <= 1'b0;
      end else begin
         vsync_q <= vsync;
         unique case (state)
            IDLE: begin
               if (cfg_we) begin
                  case (cfg_addr)
                     3'd0: begin
                        run    <= cfg_wdata[0];
                        irq_en <= cfg_wdata[1];
                        if (cfg_wdata[2]) frame_miss <= 1'b0;
                     end
                     3'd1: begin
                        vx0 <= fix_vel(cfg_wdata[3:0]);
                        vy0 <= fix_vel(cfg_wdata[7:4]);
                     end
                     3'd2: begin
                        vx1 <= fix_vel(cfg_wdata[3:0]);
                        vy1 <= fix_vel(cfg_wdata[7:4]);
                     end
                     3'd3: x0 <= clamp(cfg_wdata, XM);
                     3'd4: y0 <= clamp(cfg_wdata, YM);
                     3'd5: x1 <= clamp(cfg_wdata, XM);
                     3'd6: y1 <= clamp(cfg_wdata, YM);
                     default: ;
                  endcase
               end
               if (vs_rise && run) begin
                  state <= CALC;
                  busy  <= 1'b1;
               end
            end
            CALC: begin
               {vx0, x0}    <= step(x0, vx0, XM);
               {vy0, y0}    <= step(y0, vy0, YM);
               {vx1, x1}    <= step(x1, vx1, XM);
               {vy1, y1}    <= step(y1, vy1, YM);
               bus.wr_valid <= 1'b1;
               bus.wr_addr  <= 6'h00;
               bus.wr_data  <= {14'd0, irq_en, 1'b0};
               state        <= WR_STOP;
            end
            WR_STOP: if (xfer) begin
               bus.wr_addr <= 6'h04;
               bus.wr_data <= {y0, x0};
               state       <= WR_P0;
            end
            WR_P0: if (xfer) begin
               bus.wr_addr <= 6'h0E;
               bus.wr_data <= {y1, x1};
               state       <= WR_P1;
            end
            WR_P1: if (xfer) begin
               bus.wr_addr <= 6'h00;
               bus.wr_data <= {14'd0, irq_en, 1'b1};
               state       <= WR_GO;
            end
            WR_GO: if (xfer) begin
               bus.wr_valid <= 1'b0;
               bus.wr_addr  <= 6'h00;
               bus.wr_data  <= 16'd0;
               busy         <= 1'b0;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
         // Anything arriving mid-sequence is lost; flag it for the CPU.
         if (state != IDLE && (vs_rise || cfg_we))
            frame_miss <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sprite_motion_seq.sv
// Scoreboard bench for sprite_motion_seq: an integer motion model predicts
// each frame's four engine writes; a monitor checks every bus transfer.
module tb_sprite_motion_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       vsync = 1'b0;
   logic       cfg_we = 1'b0;
   logic [2:0] cfg_addr = 3'd0;
   logic [7:0] cfg_wdata = 8'd0;
   logic [15:0] pos0, pos1;
   logic       busy, frame_miss;

   sprite_motion_seq_if bus();

   sprite_motion_seq dut (
      .clk        (clk),
      .rst        (rst),
      .vsync      (vsync),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_wdata  (cfg_wdata),
      .bus        (bus),
      .pos0       (pos0),
      .pos1       (pos1),
      .busy       (busy),
      .frame_miss (frame_miss)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int rdy_mode = 0;

   logic [21:0] sb[$];

   int mp[4];
   int mv[4];
   int mmax[4] = '{248, 184, 248, 184};
   bit m_run, m_irq;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   function automatic int nib(logic [3:0] n);
      int x;
      x = (n >= 8) ? int'(n) - 16 : int'(n);
      if (x == -8) x = -7;
      return x;
   endfunction

   function automatic void m_reset();
      for (int i = 0; i < 4; i++) begin
         mp[i] = 0;
         mv[i] = 0;
      end
      m_run = 0;
      m_irq = 0;
      sb.delete();
   endfunction

   function automatic void m_cfg(int a, logic [7:0] d);
      case (a)
         0: begin m_run = d[0]; m_irq = d[1]; end
         1: begin mv[0] = nib(d[3:0]); mv[1] = nib(d[7:4]); end
         2: begin mv[2] = nib(d[3:0]); mv[3] = nib(d[7:4]); end
         3, 4, 5, 6: mp[a-3] = (int'(d) > mmax[a-3]) ? mmax[a-3] : int'(d);
         default: ;
      endcase
   endfunction

   function automatic logic [15:0] mpos(int s);
      return {8'(mp[2*s+1]), 8'(mp[2*s])};
   endfunction

   function automatic void m_frame();
      int n;
      for (int i = 0; i < 4; i++) begin
         n = mp[i] + mv[i];
         if (n < 0) begin mp[i] = 0; mv[i] = -mv[i]; end
         else if (n > mmax[i]) begin mp[i] = mmax[i]; mv[i] = -mv[i]; end
         else mp[i] = n;
      end
      sb.push_back({6'h00, 14'd0, m_irq, 1'b0});
      sb.push_back({6'h04, mpos(0)});
      sb.push_back({6'h0E, mpos(1)});
      sb.push_back({6'h00, 14'd0, m_irq, 1'b1});
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(int a, logic [7:0] d);
      cfg_we    = 1'b1;
      cfg_addr  = 3'(a);
      cfg_wdata = d;
      tick();
      cfg_we = 1'b0;
      m_cfg(a, d);
   endtask

   task automatic wait_idle();
      int i;
      for (i = 0; i < 300; i++) begin
         if (!busy && sb.size() == 0) break;
         tick();
      end
      chk("idle_timeout", 32'(i < 300), 32'd1);
   endtask

   task automatic check_pos();
      chk("pos0", pos0, mpos(0));
      chk("pos1", pos1, mpos(1));
   endtask

   task automatic frame();
      if (m_run) m_frame();
      vsync = 1'b1;
      tick();
      vsync = 1'b0;
      tick();
      wait_idle();
      check_pos();
   endtask

   // Ready driver: always-ready, random, or left to the stimulus.
   initial forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) bus.wr_ready = 1'b1;
      else if (rdy_mode == 1) bus.wr_ready = 1'($urandom_range(0, 1));
   end

   // Monitor: every transfer must match the head of the scoreboard.
   initial forever begin
      @(negedge clk);
      if (!rst && bus.wr_valid && bus.wr_ready) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                     bus.wr_addr, bus.wr_data);
         end else begin
            logic [21:0] e;
            e = sb.pop_front();
            chk("wr_addr", 32'(bus.wr_addr), 32'(e[21:16]));
            chk("wr_data", 32'(bus.wr_data), 32'(e[15:0]));
            chk("wr_size", 32'(bus.wr_size), 32'd1);
         end
      end
   end

   initial begin
      logic [15:0] held;
      bit          stable, any_busy;
      bus.wr_ready = 1'b1;
      m_reset();

      // Reset state and no sequence while run=0
      tick();
      tick();
      rst = 1'b0;
      chk("rst_valid", 32'(bus.wr_valid), 32'd0);
      chk("rst_addr", 32'(bus.wr_addr), 32'd0);
      chk("rst_data", 32'(bus.wr_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_miss", 32'(frame_miss), 32'd0);
      chk("rst_pos0", 32'(pos0), 32'd0);
      chk("rst_pos1", 32'(pos1), 32'd0);
      frame();
      tick();
      chk("norun_valid", 32'(bus.wr_valid), 32'd0);
      chk("norun_busy", 32'(busy), 32'd0);

      // Basic move with latency checks
      cfg(3, 8'd10);
      cfg(1, 8'h03);
      cfg(0, 8'h01);
      m_frame();
      vsync = 1'b1;
      tick();
      vsync = 1'b0;
      chk("calc_busy", 32'(busy), 32'd1);
      chk("calc_novalid", 32'(bus.wr_valid), 32'd0);
      tick();
      chk("first_valid", 32'(bus.wr_valid), 32'd1);
      tick();
      tick();
      tick();
      chk("go_busy", 32'(busy), 32'd1);
      chk("go_addr", 32'(bus.wr_addr), 32'h00);
      tick();
      chk("end_busy", 32'(busy), 32'd0);
      chk("end_valid", 32'(bus.wr_valid), 32'd0);
      chk("basic_pos0", 32'(pos0), 32'h000D);
      check_pos();

      // Bounce high then low
      cfg(3, 8'd247);
      cfg(1, 8'h03);
      frame();
      chk("bounce_hi", 32'(pos0[7:0]), 32'd248);
      frame();
      chk("bounce_hi2", 32'(pos0[7:0]), 32'd245);
      cfg(6, 8'd1);
      cfg(2, 8'hE0);
      frame();
      chk("bounce_lo", 32'(pos1[15:8]), 32'd0);
      frame();
      chk("bounce_lo2", 32'(pos1[15:8]), 32'd2);

      // Stall for 5 cycles in WR_P0
      rdy_mode = 2;
      bus.wr_ready = 1'b0;
      m_frame();
      vsync = 1'b1;
      tick();
      vsync = 1'b0;
      tick();
      chk("stall_stop_addr", 32'(bus.wr_addr), 32'h00);
      bus.wr_ready = 1'b1;
      tick();
      bus.wr_ready = 1'b0;
      chk("stall_p0_addr", 32'(bus.wr_addr), 32'h04);
      held = bus.wr_data;
      stable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (!bus.wr_valid || bus.wr_addr != 6'h04 || bus.wr_data != held)
            stable = 1'b0;
      end
      chk("stall_stable", 32'(stable), 32'd1);
      bus.wr_ready = 1'b1;
      tick();
      chk("stall_resume", 32'(bus.wr_addr), 32'h0E);
      rdy_mode = 0;
      wait_idle();
      check_pos();

      // Config write while busy is dropped and flagged
      m_frame();
      vsync = 1'b1;
      tick();
      vsync = 1'b0;
      tick();
      cfg_we = 1'b1;
      cfg_addr = 3'd3;
      cfg_wdata = 8'd0;
      tick();
      cfg_we = 1'b0;
      wait_idle();
      check_pos();
      chk("drop_miss", 32'(frame_miss), 32'd1);
      cfg(0, 8'h05);
      chk("drop_clear", 32'(frame_miss), 32'd0);

      // Overlap: VSYNC edge during WR_P1
      m_frame();
      vsync = 1'b1;
      tick();
      vsync = 1'b0;
      tick();
      tick();
      tick();
      chk("ovl_in_p1", 32'(bus.wr_addr), 32'h0E);
      vsync = 1'b1;
      tick();
      vsync = 1'b0;
      chk("ovl_miss", 32'(frame_miss), 32'd1);
      wait_idle();
      any_busy = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (busy) any_busy = 1'b1;
      end
      chk("ovl_no_extra", 32'(any_busy), 32'd0);
      cfg(0, 8'h05);
      chk("ovl_clear", 32'(frame_miss), 32'd0);

      // Config edge values
      cfg(1, 8'h88);
      cfg(3, 8'd100);
      cfg(4, 8'd100);
      frame();
      chk("vel_m8", 32'(pos0), 32'h5D5D);
      cfg(3, 8'hFF);
      chk("x_clamp", 32'(pos0[7:0]), 32'd248);
      cfg(4, 8'hFF);
      chk("y_clamp", 32'(pos0[15:8]), 32'd184);

      // Reset while in WR_P0
      cfg(0, 8'h03);
      rdy_mode = 2;
      bus.wr_ready = 1'b1;
      m_frame();
      vsync = 1'b1;
      tick();
      vsync = 1'b0;
      tick();
      tick();
      bus.wr_ready = 1'b0;
      chk("rst_mid_p0", 32'(bus.wr_addr), 32'h04);
      rst = 1'b1;
      m_reset();
      tick();
      rst = 1'b0;
      chk("rst_mid_valid", 32'(bus.wr_valid), 32'd0);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      check_pos();
      bus.wr_ready = 1'b1;
      rdy_mode = 1;

      // Random frames against the model
      cfg(0, 8'h01);
      for (int i = 3; i <= 6; i++) cfg(i, 8'($urandom));
      cfg(1, 8'($urandom));
      cfg(2, 8'($urandom));
      for (int f = 0; f < 30; f++) begin
         if ($urandom_range(0, 2) == 0)
            cfg($urandom_range(1, 6), 8'($urandom));
         if ($urandom_range(0, 4) == 0)
            cfg(0, 8'(2 * $urandom_range(0, 1) + 1));
         frame();
      end
      rdy_mode = 0;
      tick();
      chk("final_sb_empty", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
